booth_radix4_seq: RTL and testbench

Parametrised sequential radix-4 (modified) Booth multiplier. It is the successor to the team's 8-bit radix-2 Booth block and processes two multiplier bits per clock, so it needs half the iterations. It adds an explicit start/busy/done handshake and a held product register, and it sits as an arithmetic slave under a controller or datapath FSM.

---
 rtl/booth_radix4_seq.sv | 137 +++++++++++++
 tb/tb_booth_radix4_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_radix4_seq.sv
// booth_radix4_seq: sequential radix-4 (modified) Booth multiplier.
// Consumes two multiplier bits per clock. Uses a start/busy/done handshake,
// and the product register holds the last result between operations.
// Optional build macro: BOOTH_UNSIGNED_MODE_EN adds a tc input.
// tc=0 selects unsigned operands and needs one extra iteration.
module booth_radix4_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   mc,
  input  logic [WIDTH-1:0]   mp,
`ifdef BOOTH_UNSIGNED_MODE_EN
  input  logic               tc,
`endif
  output logic [2*WIDTH-1:0] prod,
  output logic               busy,
  output logic               done
);

  localparam int STEPS = WIDTH / 2;
  localparam int AW    = WIDTH + 2;          // accumulator: room for +/-2M
`ifdef BOOTH_UNSIGNED_MODE_EN
  localparam int MPW   = WIDTH + 2;          // multiplier reg sized for the unsigned extension
`else
  localparam int MPW   = WIDTH;
`endif
  localparam int CW    = $clog2(STEPS + 2);

  generate
    if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("booth_radix4_seq: WIDTH must be even and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state, state_nx;
  logic [AW-1:0]   acc, mcand;
  logic [MPW-1:0]  mpr;
  logic            app;
  logic [CW-1:0]   cnt;
`ifdef BOOTH_UNSIGNED_MODE_EN
  logic            tc_q;
`endif

  logic            accept, last;
  logic [AW-1:0]   neg_m, pp, sum, acc_nx;
  logic [MPW-1:0]  mpr_nx;
  logic [2*WIDTH-1:0] result;

  // One Booth step: recode the triplet, add the partial product, then shift by 2.
  always_comb begin
    neg_m = ~mcand + AW'(1);
    unique case ({mpr[1:0], app})
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand << 1;
      3'b100:         pp = neg_m << 1;
      3'b101, 3'b110: pp = neg_m;
      default:        pp = '0;
    endcase
    sum    = acc + pp;
    acc_nx = {sum[AW-1], sum[AW-1], sum[AW-1:2]};
    mpr_nx = {sum[1:0], mpr[MPW-1:2]};
`ifdef BOOTH_UNSIGNED_MODE_EN
    // Signed mode leaves the two sign-extension bits at the bottom of mpr.
    last   = (cnt == (tc_q ? CW'(STEPS - 1) : CW'(STEPS)));
    result = tc_q ? {acc_nx[WIDTH-1:0], mpr_nx[WIDTH+1:2]}
                  : {acc_nx[WIDTH-3:0], mpr_nx};
`else
    last   = (cnt == CW'(STEPS - 1));
    result = {acc_nx[WIDTH-1:0], mpr_nx};
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs. DONE accepts a new start with no bubble.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    accept   = 1'b0;
    unique case (state)
      IDLE: if (start) begin accept = 1'b1; state_nx = RUN; end
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin accept = 1'b1; state_nx = RUN; end
        else       state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture operands on accept, iterate while running, load prod on the last step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc   <= '0;
      mcand <= '0;
      mpr   <= '0;
      app   <= 1'b0;
      cnt   <= '0;
      prod  <= '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
      tc_q  <= 1'b0;
`endif
    end else if (accept) begin
      acc   <= '0;
      app   <= 1'b0;
      cnt   <= '0;
`ifdef BOOTH_UNSIGNED_MODE_EN
      tc_q  <= tc;
      mcand <= tc ? {{2{mc[WIDTH-1]}}, mc} : {2'b00, mc};
      mpr   <= tc ? {{2{mp[WIDTH-1]}}, mp} : {2'b00, mp};
`else
      mcand <= {{2{mc[WIDTH-1]}}, mc};
      mpr   <= mp;
`endif
    end else if (busy) begin
      acc   <= acc_nx;
      mpr   <= mpr_nx;
      app   <= mpr[1];
      cnt   <= cnt + CW'(1);
      if (last) prod <= result;
    end
  end

endmodule

// File: tb/tb_booth_radix4_seq.sv
// Self-checking bench for booth_radix4_seq at WIDTH=8 and WIDTH=16.
// A cycle-countdown model predicts busy, done and prod from plain arithmetic.
// Directed cases pin the literal products; a random sweep then exercises both widths.
module tb_booth_radix4_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n = 1'b0;
  logic        s8 = 1'b0;
  logic [7:0]  mc8 = '0, mp8 = '0;
  logic [15:0] prod8;
  logic        busy8, done8;
  logic        s16 = 1'b0;
  logic [15:0] mc16 = '0, mp16 = '0;
  logic [31:0] prod16;
  logic        busy16, done16;
`ifdef BOOTH_UNSIGNED_MODE_EN
  logic        tc8 = 1'b1, tc16 = 1'b1;
`endif

  int checks = 0, errors = 0;
  int cyc = 0, acc_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  booth_radix4_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .mc(mc8), .mp(mp8),
`ifdef BOOTH_UNSIGNED_MODE_EN
    .tc(tc8),
`endif
    .prod(prod8), .busy(busy8), .done(done8));

  booth_radix4_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .mc(mc16), .mp(mp16),
`ifdef BOOTH_UNSIGNED_MODE_EN
    .tc(tc16),
`endif
    .prod(prod16), .busy(busy16), .done(done16));

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic t);
    logic signed [15:0] sa, sb;
    sa = $signed(a); sb = $signed(b);
    if (t) return sa * sb;
    return {8'b0, a} * {8'b0, b};
  endfunction

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b, input logic t);
    logic signed [31:0] sa, sb;
    sa = $signed(a); sb = $signed(b);
    if (t) return sa * sb;
    return {16'b0, a} * {16'b0, b};
  endfunction

  // Model: a countdown of remaining iterations plus the product computed at accept.
  int rem8 = 0, rem16 = 0, ndone8 = 0, ndone16 = 0;
  logic [15:0] pend8 = '0, exp8 = '0;
  logic [31:0] pend16 = '0, exp16 = '0;
  logic expdone8 = 1'b0, expdone16 = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      rem8 <= 0; exp8 <= '0; expdone8 <= 1'b0;
    end else if (rem8 > 0) begin
      rem8     <= rem8 - 1;
      expdone8 <= (rem8 == 1);
      if (rem8 == 1) begin exp8 <= pend8; ndone8 <= ndone8 + 1; end
    end else begin
      expdone8 <= 1'b0;
      if (s8) begin
`ifdef BOOTH_UNSIGNED_MODE_EN
        pend8 <= ref8(mc8, mp8, tc8); rem8 <= tc8 ? 4 : 5;
`else
        pend8 <= ref8(mc8, mp8, 1'b1); rem8 <= 4;
`endif
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      rem16 <= 0; exp16 <= '0; expdone16 <= 1'b0;
    end else if (rem16 > 0) begin
      rem16     <= rem16 - 1;
      expdone16 <= (rem16 == 1);
      if (rem16 == 1) begin exp16 <= pend16; ndone16 <= ndone16 + 1; end
    end else begin
      expdone16 <= 1'b0;
      if (s16) begin
`ifdef BOOTH_UNSIGNED_MODE_EN
        pend16 <= ref16(mc16, mp16, tc16); rem16 <= tc16 ? 8 : 9;
`else
        pend16 <= ref16(mc16, mp16, 1'b1); rem16 <= 8;
`endif
      end
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    check("busy8",  busy8,  rem8 > 0);
    check("done8",  done8,  expdone8);
    check("prod8",  prod8,  exp8);
    check("busy16", busy16, rem16 > 0);
    check("done16", done16, expdone16);
    check("prod16", prod16, exp16);
  end

  task automatic go8(input logic [7:0] a, input logic [7:0] b);
    @(posedge clk); #1;
    s8 = 1'b1; mc8 = a; mp8 = b;
    @(posedge clk); #1;
    s8 = 1'b0; acc_cyc = cyc;
  endtask

  task automatic wait_done8(output int n);
    n = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done8) begin n = cyc - acc_cyc; break; end
    end
    if (n < 0) check("done8_timeout", 1'b0, 1'b1);
  endtask

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0: return 8'h80;
      1: return 8'hFF;
      2: return 8'h00;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] pick16();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, dn, base8, base16;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_prod", prod8, 16'h0);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;

    go8(8'hF9, 8'h03); wait_done8(n);
    check("lat_m7x3", n, 4);
    check("p_m7x3", prod8, 16'hFFEB);

    go8(8'h80, 8'h80); wait_done8(n);
    check("p_min_min", prod8, 16'h4000);
    s8 = 1'b1; mc8 = 8'h7F; mp8 = 8'h80;      // start in the DONE cycle
    @(posedge clk); #1 s8 = 1'b0; acc_cyc = cyc;
    wait_done8(n);
    check("lat_b2b", n, 4);
    check("p_max_min", prod8, 16'hC080);

    go8(8'h5A, 8'h00); wait_done8(n);
    check("p_x0", prod8, 16'h0000);
    go8(8'h5A, 8'hFF); wait_done8(n);
    check("p_xm1", prod8, 16'hFFA6);

    // Disturb start and operands during RUN; start is low again before DONE.
    go8(8'h13, 8'h25);
    for (int k = 0; k < 3; k++) begin
      s8 = (k != 1); mc8 = 8'($urandom); mp8 = 8'($urandom);
      @(posedge clk); #1;
    end
    s8 = 1'b0;
    wait_done8(n);
    check("lat_disturb", n, 4);
    check("p_disturb", prod8, 16'h02BF);

    // Abort in flight.
    go8(8'h33, 8'h44);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort_prod", prod8, 16'h0);
    check("abort_busy", busy8, 1'b0);
    check("abort_done", done8, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    dn = 0;
    repeat (8) begin @(negedge clk); if (done8) dn++; end
    check("abort_nodone", dn, 0);

`ifdef BOOTH_UNSIGNED_MODE_EN
    tc8 = 1'b0;
    go8(8'hFF, 8'hFF); wait_done8(n);
    check("lat_unsigned", n, 5);
    check("p_unsigned", prod8, 16'hFE01);
    tc8 = 1'b1;
    go8(8'hFF, 8'hFF); wait_done8(n);
    check("lat_signed", n, 4);
    check("p_signed", prod8, 16'h0001);
`endif

    base8 = ndone8; base16 = ndone16;
    fork
      begin
        for (int k = 0; k < 30000 && ndone8 < base8 + 1000; k++) begin
          @(posedge clk); #1;
          s8 = ($urandom_range(0, 2) != 0); mc8 = pick8(); mp8 = pick8();
`ifdef BOOTH_UNSIGNED_MODE_EN
          tc8 = 1'($urandom_range(0, 1));
`endif
        end
        s8 = 1'b0;
      end
      begin
        for (int k = 0; k < 30000 && ndone16 < base16 + 1000; k++) begin
          @(posedge clk); #1;
          s16 = ($urandom_range(0, 2) != 0); mc16 = pick16(); mp16 = pick16();
`ifdef BOOTH_UNSIGNED_MODE_EN
          tc16 = 1'($urandom_range(0, 1));
`endif
        end
        s16 = 1'b0;
      end
    join
    check("rand8_count",  ndone8  >= base8 + 1000, 1'b1);
    check("rand16_count", ndone16 >= base16 + 1000, 1'b1);

    repeat (12) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
